reservation_station: RTL and testbench

- Consumer end of the common data bus: a DEPTH-entry reservation station in front of one functional unit.
- Accepts dispatched instructions whose source operands are either ready (value supplied) or pending (producer tag supplied).
- Snoops every CDB broadcast (valid/tag/data) to capture pending operands.
- Issues fully-ready entries to the functional unit through a registered valid/ready output stage.

---
 rtl/reservation_station.sv | 168 ++++++++++++++++
 tb/tb_reservation_station.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - DEPTH-entry reservation station that snoops the CDB and issues ready entries
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   disp_*          : dispatch handshake, opcode, dest tag and per-source pend/tag/data
//   cdb_*           : common data bus broadcast (valid/tag/data)
//   issue_*         : registered valid/ready output stage feeding the functional unit
//   occupancy       : valid entries in the array, output stage excluded
module reservation_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    input  logic              disp_src1_pend,
    input  logic [TAG_W-1:0]  disp_src1_tag,
    input  logic [DATA_W-1:0] disp_src1_data,
    input  logic              disp_src2_pend,
    input  logic [TAG_W-1:0]  disp_src2_tag,
    input  logic [DATA_W-1:0] disp_src2_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [TAG_W-1:0]  issue_dest_tag,
    output logic [DATA_W-1:0] issue_src1,
    output logic [DATA_W-1:0] issue_src2,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]  s1_pend_q, s1_pend_d;
    logic [DEPTH-1:0]  s2_pend_q, s2_pend_d;
    logic [OP_W-1:0]   ent_op_q   [DEPTH];
    logic [OP_W-1:0]   ent_op_d   [DEPTH];
    logic [TAG_W-1:0]  ent_dest_q [DEPTH];
    logic [TAG_W-1:0]  ent_dest_d [DEPTH];
    logic [TAG_W-1:0]  s1_tag_q   [DEPTH];
    logic [TAG_W-1:0]  s1_tag_d   [DEPTH];
    logic [TAG_W-1:0]  s2_tag_q   [DEPTH];
    logic [TAG_W-1:0]  s2_tag_d   [DEPTH];
    logic [DATA_W-1:0] s1_data_q  [DEPTH];
    logic [DATA_W-1:0] s1_data_d  [DEPTH];
    logic [DATA_W-1:0] s2_data_q  [DEPTH];
    logic [DATA_W-1:0] s2_data_d  [DEPTH];

    logic              issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [TAG_W-1:0]  issue_dest_q, issue_dest_d;
    logic [DATA_W-1:0] issue_src1_q, issue_src1_d;
    logic [DATA_W-1:0] issue_src2_q, issue_src2_d;
    logic [CNT_W-1:0]  occupancy_q, occupancy_d;

    logic [DEPTH-1:0]  ready_vec, issue_sel, free_vec, disp_sel;
    logic              disp_fire, load_en, issue_fire;
    logic              src1_byp, src2_byp;

    assign disp_ready     = (occupancy_q != CNT_W'(DEPTH));
    assign issue_valid    = issue_valid_q;
    assign issue_op       = issue_op_q;
    assign issue_dest_tag = issue_dest_q;
    assign issue_src1     = issue_src1_q;
    assign issue_src2     = issue_src2_q;
    assign occupancy      = occupancy_q;

    always_comb begin
        // Selection works on pre-edge state only: an operand captured this
        // cycle makes its entry eligible next cycle, and a slot freed this
        // cycle is not offered to dispatch until next cycle.
        ready_vec  = ent_valid_q & ~s1_pend_q & ~s2_pend_q;
        issue_sel  = ready_vec & ~(ready_vec - DEPTH'(1));
        free_vec   = ~ent_valid_q;
        disp_sel   = free_vec & ~(free_vec - DEPTH'(1));
        disp_fire  = disp_valid & disp_ready;
        load_en    = ~issue_valid_q | issue_ready;
        issue_fire = load_en & (|ready_vec);

        // A broadcast in the dispatch cycle would otherwise be missed forever.
        src1_byp = disp_src1_pend & cdb_valid & (cdb_tag == disp_src1_tag);
        src2_byp = disp_src2_pend & cdb_valid & (cdb_tag == disp_src2_tag);

        ent_valid_d = ent_valid_q;
        s1_pend_d   = s1_pend_q;
        s2_pend_d   = s2_pend_q;
        ent_op_d    = ent_op_q;
        ent_dest_d  = ent_dest_q;
        s1_tag_d    = s1_tag_q;
        s2_tag_d    = s2_tag_q;
        s1_data_d   = s1_data_q;
        s2_data_d   = s2_data_q;

        issue_valid_d = load_en ? (|ready_vec) : issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_dest_d  = issue_dest_q;
        issue_src1_d  = issue_src1_q;
        issue_src2_d  = issue_src2_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && ent_valid_q[i] && s1_pend_q[i] && (s1_tag_q[i] == cdb_tag)) begin
                s1_pend_d[i] = 1'b0;
                s1_data_d[i] = cdb_data;
            end
            if (cdb_valid && ent_valid_q[i] && s2_pend_q[i] && (s2_tag_q[i] == cdb_tag)) begin
                s2_pend_d[i] = 1'b0;
                s2_data_d[i] = cdb_data;
            end
            if (load_en && issue_sel[i]) begin
                issue_op_d     = ent_op_q[i];
                issue_dest_d   = ent_dest_q[i];
                issue_src1_d   = s1_data_q[i];
                issue_src2_d   = s2_data_q[i];
                ent_valid_d[i] = 1'b0;
            end
            if (disp_fire && disp_sel[i]) begin
                ent_valid_d[i] = 1'b1;
                ent_op_d[i]    = disp_op;
                ent_dest_d[i]  = disp_dest_tag;
                s1_pend_d[i]   = disp_src1_pend & ~src1_byp;
                s1_tag_d[i]    = disp_src1_tag;
                s1_data_d[i]   = src1_byp ? cdb_data : disp_src1_data;
                s2_pend_d[i]   = disp_src2_pend & ~src2_byp;
                s2_tag_d[i]    = disp_src2_tag;
                s2_data_d[i]   = src2_byp ? cdb_data : disp_src2_data;
            end
        end

        occupancy_d = occupancy_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid_q   <= '0;
            s1_pend_q     <= '0;
            s2_pend_q     <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_dest_q  <= '0;
            issue_src1_q  <= '0;
            issue_src2_q  <= '0;
            occupancy_q   <= '0;
        end else begin
            ent_valid_q   <= ent_valid_d;
            s1_pend_q     <= s1_pend_d;
            s2_pend_q     <= s2_pend_d;
            ent_op_q      <= ent_op_d;
            ent_dest_q    <= ent_dest_d;
            s1_tag_q      <= s1_tag_d;
            s2_tag_q      <= s2_tag_d;
            s1_data_q     <= s1_data_d;
            s2_data_q     <= s2_data_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_dest_q  <= issue_dest_d;
            issue_src1_q  <= issue_src1_d;
            issue_src2_q  <= issue_src2_d;
            occupancy_q   <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              disp_valid = 1'b0, disp_ready;
    logic [OP_W-1:0]   disp_op = '0;
    logic [TAG_W-1:0]  disp_dest_tag = '0;
    logic              disp_src1_pend = 1'b0, disp_src2_pend = 1'b0;
    logic [TAG_W-1:0]  disp_src1_tag = '0, disp_src2_tag = '0;
    logic [DATA_W-1:0] disp_src1_data = '0, disp_src2_data = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              issue_valid, issue_ready = 1'b0;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_dest_tag;
    logic [DATA_W-1:0] issue_src1, issue_src2;
    logic [2:0]        occupancy;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_dest_tag(disp_dest_tag),
        .disp_src1_pend(disp_src1_pend), .disp_src1_tag(disp_src1_tag), .disp_src1_data(disp_src1_data),
        .disp_src2_pend(disp_src2_pend), .disp_src2_tag(disp_src2_tag), .disp_src2_data(disp_src2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_dest_tag(issue_dest_tag), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
    } exp_t;
    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] dest;
        int               cyc;
    } log_t;

    exp_t              exp_q[$];
    log_t              iss_log[$];
    logic [DATA_W-1:0] tagval [32];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one dispatch for a cycle; the expected issue payload goes to
    // the scoreboard only when the station can accept it.
    task automatic disp_cycle(input int op, input int dest,
                              input int p1, input int t1, input int d1,
                              input int p2, input int t2, input int d2,
                              input int e1, input int e2);
        disp_valid     = 1'b1;
        disp_op        = OP_W'(op);
        disp_dest_tag  = TAG_W'(dest);
        disp_src1_pend = 1'(p1);
        disp_src1_tag  = TAG_W'(t1);
        disp_src1_data = DATA_W'(d1);
        disp_src2_pend = 1'(p2);
        disp_src2_tag  = TAG_W'(t2);
        disp_src2_data = DATA_W'(d2);
        if (disp_ready)
            exp_q.push_back('{OP_W'(op), TAG_W'(dest), DATA_W'(e1), DATA_W'(e2)});
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic cdb_cycle(input int tag, input int data);
        cdb_valid = 1'b1;
        cdb_tag   = TAG_W'(tag);
        cdb_data  = DATA_W'(data);
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (iss_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (iss_log.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d issues, required %0d", name, iss_log.size(), n);
        end
    endtask

    function automatic int last_cyc();
        if (iss_log.size() == 0) return -1000;
        return iss_log[iss_log.size()-1].cyc;
    endfunction

    // Monitor: every accepted issue must match an outstanding expectation.
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (!rst && issue_valid && issue_ready) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].op == issue_op && exp_q[i].dest == issue_dest_tag) begin
                        idx = i;
                        break;
                    end
                end
                iss_log.push_back('{issue_op, issue_dest_tag, cyc});
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got op=%0d dest=%0d, required no issue", issue_op, issue_dest_tag);
                end else begin
                    if (exp_q[idx].s1 !== issue_src1 || exp_q[idx].s2 !== issue_src2) begin
                        errors++;
                        $display("FAIL issue_payload op=%0d dest=%0d: got src1=0x%0h src2=0x%0h, required src1=0x%0h src2=0x%0h",
                                 issue_op, issue_dest_tag, issue_src1, issue_src2, exp_q[idx].s1, exp_q[idx].s2);
                    end
                    exp_q.delete(idx);
                end
            end
        end
    end

    initial begin
        int d, b, n, seq;
        logic [10:0] sq;
        int p1, t1, d1, p2, t2, d2, e1, e2;

        // Reset state
        rst = 1'b1;
        issue_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_op", issue_op, 0);
        chk("rst_issue_dest", issue_dest_tag, 0);
        chk("rst_issue_src1", issue_src1, 0);
        chk("rst_issue_src2", issue_src2, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_disp_ready", disp_ready, 1);

        // Ready-at-dispatch instruction issues two cycles later
        d = cyc;
        disp_cycle(3, 7, 0, 0, 10, 0, 0, 20, 10, 20);
        wait_log(1, 10, "t1");
        chk("t1_latency", last_cyc() - d, 2);
        tick();
        chk("t1_occupancy", occupancy, 0);

        // Pending src1 woken by CDB; non-matching tag ignored
        disp_cycle(4, 8, 1, 5, 'hDEAD, 0, 0, 'h22, 'hAB, 'h22);
        cdb_cycle(6, 'h66);
        tick(); tick(); tick();
        chk("t2_no_early_issue", iss_log.size(), 1);
        chk("t2_occupancy_wait", occupancy, 1);
        b = cyc;
        cdb_cycle(5, 'hAB);
        wait_log(2, 10, "t2");
        chk("t2_latency", last_cyc() - b, 2);

        // Dispatch bypass from a same-cycle broadcast
        cdb_valid = 1'b1; cdb_tag = 9; cdb_data = 'h55;
        d = cyc;
        disp_cycle(5, 9, 1, 9, 'hBEEF, 0, 0, 1, 'h55, 1);
        cdb_valid = 1'b0;
        wait_log(3, 10, "t3");
        chk("t3_latency", last_cyc() - d, 2);

        // Fill, drop when full, wake all with one broadcast
        for (int k = 0; k < 4; k++)
            disp_cycle(10 + k, 16 + k, 1, 3, 'h1000 + k, 0, 0, 'h200 + k, 'h33, 'h200 + k);
        chk("t4_disp_ready_full", disp_ready, 0);
        chk("t4_occupancy_full", occupancy, 4);
        disp_cycle(20, 20, 0, 0, 1, 0, 0, 2, 1, 2);
        chk("t4_occupancy_drop", occupancy, 4);
        b = cyc;
        cdb_cycle(3, 'h33);
        wait_log(7, 20, "t4");
        for (int k = 0; k < 4; k++) begin
            if (iss_log.size() > 3 + k) begin
                chk("t4_order", iss_log[3+k].op, 10 + k);
                chk("t4_cycle", iss_log[3+k].cyc - b, 2 + k);
            end
        end
        tick(); tick(); tick();
        chk("t4_dropped_never_issues", iss_log.size(), 7);

        // Stall holds outputs; concurrent dispatch and release
        issue_ready = 1'b0;
        disp_cycle(30, 1, 0, 0, 'hA1, 0, 0, 'hA2, 'hA1, 'hA2);
        disp_cycle(31, 2, 0, 0, 'hB1, 0, 0, 'hB2, 'hB1, 'hB2);
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_valid", issue_valid, 1);
            chk("t5_stall_op", issue_op, 30);
            chk("t5_stall_src1", issue_src1, 'hA1);
            chk("t5_stall_occ", occupancy, 1);
            tick();
        end
        issue_ready = 1'b1;
        disp_cycle(32, 3, 0, 0, 'hC1, 0, 0, 'hC2, 'hC1, 'hC2);
        chk("t5_occ_concurrent", occupancy, 1);
        chk("t5_next_loaded", issue_op, 31);
        wait_log(10, 10, "t5");

        // Reset discards entries and the stalled output
        issue_ready = 1'b0;
        disp_cycle(40, 4, 0, 0, 1, 0, 0, 2, 1, 2);
        for (int k = 0; k < 3; k++)
            disp_cycle(41 + k, 5 + k, 1, 12, 0, 0, 0, 3, 'hCC, 3);
        chk("t6_occ_before", occupancy, 3);
        chk("t6_valid_before", issue_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", issue_valid, 0);
        chk("t6_rst_occ", occupancy, 0);
        chk("t6_rst_disp_ready", disp_ready, 1);
        exp_q.delete();
        issue_ready = 1'b1;
        n = iss_log.size();
        cdb_cycle(12, 'hCC);
        tick(); tick(); tick(); tick();
        chk("t6_no_stale_issue", iss_log.size(), n);

        // Randomized traffic: each tag always broadcasts the same value,
        // so an operand's final value is known at dispatch time.
        for (int t = 0; t < 32; t++) tagval[t] = $urandom;
        seq = 0;
        for (int c = 0; c < 400; c++) begin
            cdb_valid   = ($urandom_range(0, 99) < 40);
            cdb_tag     = TAG_W'($urandom_range(0, 7));
            cdb_data    = tagval[cdb_tag];
            issue_ready = ($urandom_range(0, 99) < 70);
            chk("rand_disp_ready_vs_occ", disp_ready, (occupancy != 3'(DEPTH)) ? 1 : 0);
            if ($urandom_range(0, 99) < 50) begin
                sq = seq[10:0];
                p1 = int'($urandom_range(0, 1)); t1 = int'($urandom_range(0, 7)); d1 = int'($urandom);
                p2 = int'($urandom_range(0, 1)); t2 = int'($urandom_range(0, 7)); d2 = int'($urandom);
                e1 = (p1 != 0) ? int'(tagval[t1]) : d1;
                e2 = (p2 != 0) ? int'(tagval[t2]) : d2;
                if (disp_ready) seq++;
                disp_cycle(int'(sq[5:0]), int'(sq[10:6]), p1, t1, d1, p2, t2, d2, e1, e2);
            end else begin
                tick();
            end
        end

        // Drain by broadcasting every tag in use
        cdb_valid = 1'b0;
        issue_ready = 1'b1;
        for (int k = 0; k < 300 && exp_q.size() > 0; k++)
            cdb_cycle(k % 8, int'(tagval[k % 8]));
        tick(); tick(); tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_occupancy", occupancy, 0);
        chk("drain_issue_valid", issue_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
